// File: rtl/sort_result_monitor.sv
// Sort-result monitor: snapshots an array, waits for the core's done-flag store, then
// checks order, permutation signature and cycle budget. Optional macro: SORT_MON_SIGNED_EN.
module sort_result_monitor #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 14,
    parameter int ARRAY_LEN  = 10,
    parameter int BASE_WORD  = 64,
    parameter int DONE_WORD  = 128,
    parameter int DESCENDING = 0,
    parameter int MAX_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           mon_we,
    input  logic [ADDR_W-1:0]              mon_addr,
    input  logic [XLEN-1:0]                mon_wdata,
    output logic [ADDR_W-3:0]              rd_addr,
    input  logic [XLEN-1:0]                rd_data,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           fail_timeout,
    output logic                           fail_order,
    output logic                           fail_sum,
    output logic [$clog2(ARRAY_LEN+1)-1:0] err_index,
    output logic [31:0]                    cycle_count
);
    localparam int IW = $clog2(ARRAY_LEN+1);
    localparam int AW = ADDR_W-2;

    typedef enum logic [2:0] {S_IDLE, S_PRESCAN, S_RUN, S_POSTSCAN, S_DONE} state_t;
    state_t state, state_nx;

    logic [IW-1:0]   idx;
    logic [XLEN-1:0] pre_sum, pre_xor, post_sum, post_xor, prev;
    logic [XLEN-1:0] post_sum_nx, post_xor_nx;
    logic            last, done_evt, timeout_hit, gt, lt, viol;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^mon_addr[1:0];

    assign last        = (idx == IW'(ARRAY_LEN-1));
    assign done_evt    = mon_we && (mon_addr[ADDR_W-1:2] == AW'(DONE_WORD)) && (mon_wdata == XLEN'(1));
    assign timeout_hit = ((cycle_count + 32'd1) == 32'(MAX_CYCLES));
    assign post_sum_nx = post_sum + rd_data;
    assign post_xor_nx = post_xor ^ rd_data;

`ifdef SORT_MON_SIGNED_EN
    assign gt = $signed(prev) > $signed(rd_data);
    assign lt = $signed(prev) < $signed(rd_data);
`else
    assign gt = prev > rd_data;
    assign lt = prev < rd_data;
`endif
    // element 0 has no predecessor, so ARRAY_LEN=1 never flags an order error
    assign viol = (idx != '0) && ((DESCENDING != 0) ? lt : gt);

    assign busy = (state == S_PRESCAN) || (state == S_RUN) || (state == S_POSTSCAN);
    assign done = (state == S_DONE);
    assign pass = done && !(fail_timeout || fail_order || fail_sum);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_PRESCAN;
            S_PRESCAN:      if (last) state_nx = S_RUN;
            S_RUN: begin
                // the flag write takes priority over a coincident timeout
                if (done_evt)         state_nx = S_POSTSCAN;
                else if (timeout_hit) state_nx = S_DONE;
            end
            S_POSTSCAN:     if (last) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            rd_addr      <= '0;
            pre_sum      <= '0;
            pre_xor      <= '0;
            post_sum     <= '0;
            post_xor     <= '0;
            prev         <= '0;
            fail_timeout <= 1'b0;
            fail_order   <= 1'b0;
            fail_sum     <= 1'b0;
            err_index    <= '0;
            cycle_count  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx          <= '0;
                        rd_addr      <= AW'(BASE_WORD);
                        pre_sum      <= '0;
                        pre_xor      <= '0;
                        post_sum     <= '0;
                        post_xor     <= '0;
                        prev         <= '0;
                        fail_timeout <= 1'b0;
                        fail_order   <= 1'b0;
                        fail_sum     <= 1'b0;
                        err_index    <= '0;
                        cycle_count  <= '0;
                    end
                end
                S_PRESCAN: begin
                    pre_sum <= pre_sum + rd_data;
                    pre_xor <= pre_xor ^ rd_data;
                    if (!last) begin
                        idx     <= idx + 1'b1;
                        rd_addr <= AW'(BASE_WORD + int'(idx) + 1);
                    end
                end
                S_RUN: begin
                    if (done_evt) begin
                        idx     <= '0;
                        rd_addr <= AW'(BASE_WORD);
                    end else begin
                        cycle_count <= cycle_count + 32'd1;
                        if (timeout_hit) fail_timeout <= 1'b1;
                    end
                end
                S_POSTSCAN: begin
                    post_sum <= post_sum_nx;
                    post_xor <= post_xor_nx;
                    prev     <= rd_data;
                    if (viol && !fail_order) begin
                        fail_order <= 1'b1;
                        err_index  <= idx;
                    end
                    if (last) begin
                        fail_sum <= (post_sum_nx != pre_sum) || (post_xor_nx != pre_xor);
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_addr <= AW'(BASE_WORD + int'(idx) + 1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sort_result_monitor.md
# sort_result_monitor

Parametrised self-checking monitor for array-sort programs running on the `RISCVPipelined` core. It snapshots a data-memory array before the core runs. It then watches the core's memory-stage store port for a done-flag write. After that write it rescans the array and checks three things: sort order, that the contents are still a permutation (by sum and XOR signature), and the cycle budget. It sits beside the core in simulation and FPGA builds. It reads data memory through a dedicated read port, so the bench-side memory peeking of earlier sort tests is replaced by a reusable checker.

## Interface
- `XLEN`, 32, data word width
- `ADDR_W`, 14, byte-address width of the monitored store port
- `ARRAY_LEN`, 10, number of array words (≥1)
- `BASE_WORD`, 64, word address of element 0
- `DONE_WORD`, 128, word address of the done flag
- `DESCENDING`, 0, 0 = ascending order required, 1 = descending order required
- `MAX_CYCLES`, 500, RUN-state cycle budget (≥1)

Ports:
- `clk` in 1: clock. One clock domain only.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a check. Ignored while `busy`.
- `mon_we` in 1: store enable from the memory stage (`memWrite_M`).
- `mon_addr` in ADDR_W: store byte address (`ALUResult_M[ADDR_W-1:0]`).
- `mon_wdata` in XLEN: store data (`writeData_M`).
- `rd_addr` out ADDR_W-2: word address to data memory.
- `rd_data` in XLEN: combinational read data for `rd_addr`, valid in the same cycle.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: check finished. Held until the next accepted `start` or `reset`.
- `pass` out 1: `done` with no failure.
- `fail_timeout`, `fail_order`, `fail_sum` out 1 each: sticky failure causes.
- `err_index` out $clog2(ARRAY_LEN+1): index of the first order violation.
- `cycle_count` out 32: RUN cycles elapsed.

## Operation
- Reset: state IDLE. Every output is 0, including `rd_addr`, `err_index` and `cycle_count`.
- IDLE: when `start` is high, clear the flags, `cycle_count`, the index `i` and the accumulators, then go to PRESCAN.
- PRESCAN: for `i` = 0..ARRAY_LEN-1, drive `rd_addr` = BASE_WORD+i. Accumulate `pre_sum` (mod 2^XLEN) and `pre_xor`. After the last read, go to RUN.
- RUN: the done event is `mon_we` && `mon_addr[ADDR_W-1:2]`==DONE_WORD && `mon_wdata`==1.
  - On the done event, go to POSTSCAN. `cycle_count` is not incremented in that cycle.
  - Otherwise increment `cycle_count`. When it reaches MAX_CYCLES, set `fail_timeout` and go to DONE.
  - Writes to the flag with any value other than 1 are ignored. Stores to any other address are ignored.
- POSTSCAN: read `rd_addr` = BASE_WORD+i and accumulate `post_sum` and `post_xor`.
  - For i≥1, compare `rd_data` with the registered previous element. A violation is prev>cur when ascending, prev<cur when descending.
  - On the first violation, set `fail_order` and latch `err_index`=i. Later violations do not change it.
  - The scan always completes. At the end, set `fail_sum` if the sums or the XORs differ, then go to DONE.
- DONE: `done`=1 and `pass`=!(any fail). `busy`=0. `start` re-arms, as in IDLE.
- ARRAY_LEN=1: the order check passes trivially.
- A done event and the timeout threshold in the same cycle: the done event wins.
- `reset` in any state returns to IDLE with all outputs 0, whatever operation is in progress.

## Timing
- `start` sampled high at edge k: `busy` is high from k+1. PRESCAN occupies cycles k+1..k+ARRAY_LEN. RUN starts at k+ARRAY_LEN+1.
- Done event sampled at edge d: POSTSCAN occupies d+1..d+ARRAY_LEN. `done`, `pass` and the fail flags are valid from d+ARRAY_LEN+1.
- Timeout: `done` is valid in the cycle after the edge at which `cycle_count` reaches MAX_CYCLES.
- `rd_addr` changes only on clock edges and is held at its last value in RUN and DONE.
- The core must be held in reset until PRESCAN completes, i.e. `busy` has been high for ARRAY_LEN cycles.

## Configuration
- `SORT_MON_SIGNED_EN`:
  - Defined: order comparisons treat elements as two's-complement signed XLEN values.
  - Undefined: comparisons are unsigned.
  - The sum and XOR signatures are identical in both builds.

## Test plan
- Array 10..1, core stores 1..10 and then writes 1 to word 128 at RUN cycle 320 → `pass`=1, `cycle_count`=320, all fails 0.
- Core only swaps elements 0/1 and spins, never writing the flag → `fail_timeout`=1 after exactly 500 RUN cycles, `pass`=0.
- Final array [1,2,4,3,5,6,7,8,9,10] plus flag write → `fail_order`=1, `err_index`=3, `fail_sum`=0.
- Final array sorted but element 10 replaced by 11 → `fail_sum`=1, `fail_order`=0.
- DESCENDING=1, array 10..1 left untouched plus flag write → `pass`=1. With `SORT_MON_SIGNED_EN`, array [3,0,-1] descending → `pass`=1.
- `reset` asserted mid-RUN at cycle 50 → all outputs 0 the next cycle. A following `start` runs a fresh PRESCAN.
